// File: rtl/fb_draw_sched.sv
// Per-frame framebuffer scheduler: clears to a background index, starts and paces the
// renderer, and owns the framebuffer write port so clear and draw writes never collide.
module fb_draw_sched #(
  parameter int CIDXW      = 4,
  parameter int ADDRW      = 16,
  parameter int FB_PIXELS  = 57600,
  parameter int FRAME_WAIT = 200,
  parameter int PACE       = 1,
  parameter int LAT_FLUSH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             en,
  input  logic [CIDXW-1:0] bg_cidx,
  input  logic             draw_we,
  input  logic [ADDRW-1:0] draw_addr,
  input  logic [CIDXW-1:0] draw_cidx,
  input  logic             draw_done,
  output logic             draw_start,
  output logic             draw_oe,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [CIDXW-1:0] fb_cidx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_HOLD, S_IDLE, S_CLEAR, S_START, S_DRAW, S_FLUSH
  } state_t;

  localparam state_t RST_STATE = (FRAME_WAIT == 0) ? S_IDLE : S_HOLD;
  localparam int HOLD_W  = (FRAME_WAIT > 0) ? $clog2(FRAME_WAIT + 1) : 1;
  localparam int FLUSH_W = (LAT_FLUSH > 0) ? $clog2(LAT_FLUSH + 1) : 1;
  localparam logic [ADDRW-1:0]   CLR_LAST   = ADDRW'(FB_PIXELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((FRAME_WAIT > 0) ? FRAME_WAIT - 1 : 0);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((LAT_FLUSH > 0) ? LAT_FLUSH - 1 : 0);
  localparam logic               FLUSH_FWD  = (LAT_FLUSH > 0);
  localparam logic               PACED      = (PACE != 0);

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ADDRW-1:0]   clr_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [CIDXW-1:0]   bg_q;
  logic               clr_last, flush_last, fwd;

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr_last   = (clr_cnt == CLR_LAST);
    flush_last = (flush_cnt == FLUSH_LAST);
    fwd        = (state == S_DRAW) || ((state == S_FLUSH) && FLUSH_FWD);
    case (state)
      S_HOLD:  if (frame && (hold_cnt == HOLD_LAST)) state_nxt = S_IDLE;
      S_IDLE:  if (frame && en) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_last) state_nxt = S_START;
      S_START: state_nxt = S_DRAW;
      S_DRAW:  if (draw_done) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_last) state_nxt = S_IDLE;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Background colour is captured only on the frame that launches a schedule
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && frame && en) bg_q <= bg_cidx;
  end

  // Output stage: every port is registered one cycle behind the internal source
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      clr_cnt    <= '0;
      flush_cnt  <= '0;
      draw_start <= 1'b0;
      draw_oe    <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_cidx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if ((state == S_HOLD) && frame) hold_cnt <= hold_cnt + 1'b1;
      if (state == S_IDLE)       clr_cnt <= '0;
      else if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_DRAW)       flush_cnt <= '0;
      else if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;

      draw_start <= (state == S_CLEAR) && clr_last;
      draw_oe    <= (state == S_DRAW) && (PACED ? frame : 1'b1);
      // busy drops in the same cycle done pulses
      busy       <= (state == S_CLEAR) || (state == S_START) || (state == S_DRAW) ||
                    ((state == S_FLUSH) && !flush_last);
      done       <= (state == S_FLUSH) && flush_last;
      fb_we      <= (state == S_CLEAR) || (fwd && draw_we);
      if (state == S_CLEAR) begin
        fb_addr <= clr_cnt;
        fb_cidx <= bg_q;
      end else if (fwd && draw_we) begin
        fb_addr <= draw_addr;
        fb_cidx <= draw_cidx;
      end
    end
  end

endmodule
